// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate-generation stage with skid buffer and flush
//
// Purpose: classifies each instruction by opcode, forms the XLEN-bit immediate and
// hands it downstream over a valid/ready handshake. With SKID_EN=1 a one-entry skid
// register keeps in_ready a pure register output; with SKID_EN=0 a single register
// is used and in_ready = out_ready | ~out_valid.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             drop every held and incoming instruction
//   in_valid/in_ready input handshake; in_instr (32b), in_pc (XLEN) payload
//   out_valid/out_ready output handshake
//   out_instr, out_pc carried-through instruction and PC
//   out_imm           formed immediate
//   out_fmt           0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal       opcode not recognised
module imm_gen_stage #(
    parameter int XLEN    = 64,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Immediate decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [2:0]  fmt_c;
    logic        illegal_c;
    logic [63:0] imm_full;
    entry_t      new_entry;

    always_comb begin
        fmt_c     = FMT_NONE;
        illegal_c = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            illegal_c = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0010011, 7'b0011011,
                7'b0000011, 7'b1100111: fmt_c = FMT_I;
                7'b0100011:             fmt_c = FMT_S;
                7'b1100011:             fmt_c = FMT_B;
                7'b0110111, 7'b0010111: fmt_c = FMT_U;
                7'b1101111:             fmt_c = FMT_J;
                // funct3[2] selects the CSR immediate (uimm) forms
                7'b1110011:             fmt_c = in_instr[14] ? FMT_Z : FMT_I;
                default:                illegal_c = 1'b1;
            endcase
        end
    end

    // Built at 64 bits and truncated, so XLEN=32 needs no separate field layout.
    always_comb begin
        imm_full = 64'd0;
        case (fmt_c)
            FMT_I: imm_full = {{52{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm_full = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm_full = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm_full = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
            FMT_J: imm_full = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z: imm_full = {59'd0, in_instr[19:15]};
            default: imm_full = 64'd0;
        endcase
    end

    always_comb begin
        new_entry.instr   = in_instr;
        new_entry.pc      = in_pc;
        new_entry.imm     = imm_full[XLEN-1:0];
        new_entry.fmt     = fmt_c;
        new_entry.illegal = illegal_c;
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q;
    logic   load_new, load_skid, move_skid, load_main;
    logic   accept;

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~out_valid);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d  = S_ONE;
                    load_new = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && out_ready) begin
                    load_new = 1'b1;
                end else if (accept) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_ready) begin
                    state_d   = S_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush discards both held entries and the input of this cycle.
        if (flush) begin
            state_d   = S_EMPTY;
            load_new  = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    assign in_ready_d = (state_d != S_TWO);
    assign load_main  = load_new | move_skid;
    assign main_d     = move_skid ? skid_q : new_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_main) begin
                main_q <= main_d;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage (XLEN 64 and 32)
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_instr;
    logic [63:0] out_pc, out_imm;
    logic [2:0]  out_fmt;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_instr32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_instr(out_instr32), .out_pc(out_pc32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } item_t;

    item_t       model_q[$];
    logic [31:0] popped[$];
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written with whole-word arithmetic on the instruction.
    function automatic item_t ref_item(input logic [31:0] instr, input logic [63:0] pc);
        item_t       it;
        longint      sx;
        longint      ux;
        int          sw;
        logic [6:0]  op;
        sw = instr;
        sx = sw;                 // sign-extended copy
        ux = {32'd0, instr};     // zero-extended copy
        op = instr[6:0];
        it.instr = instr;
        it.pc    = pc;
        it.fmt   = 3'd0;
        it.ill   = 1'b0;
        if (instr[1:0] != 2'b11) it.ill = 1'b1;
        else if (op == 7'h13 || op == 7'h1B || op == 7'h03 || op == 7'h67) it.fmt = 3'd1;
        else if (op == 7'h23) it.fmt = 3'd2;
        else if (op == 7'h63) it.fmt = 3'd3;
        else if (op == 7'h37 || op == 7'h17) it.fmt = 3'd4;
        else if (op == 7'h6F) it.fmt = 3'd5;
        else if (op == 7'h73) it.fmt = ((ux >> 14) & 1) != 0 ? 3'd6 : 3'd1;
        else it.ill = 1'b1;
        case (it.fmt)
            3'd1: it.imm = sx >>> 20;
            3'd2: it.imm = ((sx >>> 25) <<< 5) | ((ux >> 7) & 31);
            3'd3: it.imm = ((sx >>> 31) <<< 12) | (((ux >> 7) & 1) << 11)
                         | (((ux >> 25) & 63) << 5) | (((ux >> 8) & 15) << 1);
            3'd4: it.imm = sx & ~longint'(4095);
            3'd5: it.imm = ((sx >>> 31) <<< 20) | (((ux >> 12) & 255) << 12)
                         | (((ux >> 20) & 1) << 11) | (((ux >> 21) & 1023) << 1);
            3'd6: it.imm = (ux >> 15) & 31;
            default: it.imm = 64'd0;
        endcase
        return it;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, model_q.size() > 0);
        chk("in_ready", in_ready, model_q.size() < 2);
        chk("out_valid32", out_valid32, model_q.size() > 0);
        chk("in_ready32", in_ready32, model_q.size() < 2);
        if (model_q.size() > 0) begin
            chk("out_instr", out_instr, model_q[0].instr);
            chk("out_pc", out_pc, model_q[0].pc);
            chk("out_imm", out_imm, model_q[0].imm);
            chk("out_fmt", out_fmt, model_q[0].fmt);
            chk("out_illegal", out_illegal, model_q[0].ill);
            chk("out_imm32", out_imm32, model_q[0].imm[31:0]);
            chk("out_pc32", out_pc32, model_q[0].pc[31:0]);
            chk("out_fmt32", out_fmt32, model_q[0].fmt);
        end
    endtask

    // One clock: decide transfers from the model's occupancy, advance, then check.
    task automatic step();
        bit fi, fo;
        fi = in_valid && (model_q.size() < 2);
        fo = out_ready && (model_q.size() > 0);
        last_acc = 1'b0;
        @(posedge clk);
        #1;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (fo) popped.push_back(model_q.pop_front().instr);
            if (fi) begin
                model_q.push_back(ref_item(in_instr, in_pc));
                last_acc = 1'b1;
            end
        end
        check_outputs();
    endtask

    task automatic send_one(input logic [31:0] instr);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = in_pc + 64'd4;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[11];
        logic [31:0] w;
        ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 10) != 10) w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 64'h1000;
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_instr", out_instr, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_fmt", out_fmt, 64'd0);
        chk("rst_out_illegal", out_illegal, 64'd0);

        // Directed immediates
        send_one(32'hFFF00093);
        chk("addi_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_fmt", out_fmt, 3'd1);
        chk("addi_ill", out_illegal, 1'b0);
        send_one(32'h800000B7);
        chk("lui_imm", out_imm, 64'hFFFFFFFF80000000);
        chk("lui_fmt", out_fmt, 3'd4);
        chk("lui_imm32", out_imm32, 32'h80000000);
        send_one(32'hFE000EE3);
        chk("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_fmt", out_fmt, 3'd3);
        send_one(32'h008000EF);
        chk("jal_imm", out_imm, 64'd8);
        chk("jal_fmt", out_fmt, 3'd5);
        send_one(32'h300FD073);
        chk("csrrwi_imm", out_imm, 64'd31);
        chk("csrrwi_fmt", out_fmt, 3'd6);
        send_one(32'h00000000);
        chk("zero_imm", out_imm, 64'd0);
        chk("zero_fmt", out_fmt, 3'd0);
        chk("zero_ill", out_illegal, 1'b1);
        step();

        // Back-pressure: A, B fill the stage, C waits
        popped.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093; in_pc = 64'h2000; step();
        in_instr  = 32'h00200113; in_pc = 64'h2004; step();
        chk("bp_in_ready_low", in_ready, 1'b0);
        in_instr  = 32'h00300193; in_pc = 64'h2008; step();
        chk("bp_head_is_A", out_instr, 32'h00100093);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 32'h00100093);
            chk("bp_order1", popped[1], 32'h00200113);
            chk("bp_order2", popped[2], 32'h00300193);
        end

        // Flush from TWO with an input presented, then the same with reset
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_instr  = 32'h00500293; step();
            in_instr  = 32'h00600313; step();
            chk("two_before_drop", in_ready, 1'b0);
            in_instr  = 32'h00700393;
            if (pass == 0) flush = 1'b1; else reset = 1'b1;
            step();
            flush = 1'b0; reset = 1'b0; in_valid = 1'b0;
            chk("drop_out_valid", out_valid, 1'b0);
            chk("drop_in_ready", in_ready, 1'b1);
            out_ready = 1'b1;
            popped.delete();
            for (int i = 0; i < 4; i++) step();
            chk("drop_nothing_emerges", popped.size(), 0);
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 39) == 0;
            reset     = $urandom_range(0, 149) == 0;
            step();
        end
        flush = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
